fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits around the 8-bit program counter register. It takes the current PC, fetches a 16-bit instruction from instruction memory over a request/acknowledge interface, and presents the instruction downstream with a valid/ready handshake. It drives Next_PC back to the PC register: increment on a successful fetch, redirect on a taken branch, hold otherwise. It stops fetching after delivering a HALT instruction.

## Interface
- ADDR_W, 8, PC and memory address width
- INSTR_W, 16, instruction width
- Clk  in  1  clock, all state updates on rising edge
- Clear_n  in  1  asynchronous active-low reset
- PC  in  ADDR_W  current program counter from the PC register
- Next_PC  out  ADDR_W  value the PC register loads on the next edge
- Mem_Req  out  1  fetch request, level
- Mem_Addr  out  ADDR_W  fetch address, equals PC
- Mem_Ack  in  1  one-cycle pulse; Mem_Data is valid in the same cycle
- Mem_Data  in  INSTR_W  fetched instruction word
- Instr  out  INSTR_W  registered instruction to decode
- Instr_Valid  out  1  Instr holds an undelivered instruction
- Instr_Ready  in  1  decode accepts Instr this cycle
- Branch_Taken  in  1  redirect request from execute, single cycle
- Branch_Target  in  ADDR_W  redirect address
- Halted  out  1  HALT delivered; fetching stopped

## Operation
- States: IDLE, REQ, HOLD, HALTED.
- Reset: state=IDLE, Instr=16'h0000, Instr_Valid=0, Halted=0. Mem_Req=0 during reset.
- IDLE: always goes to REQ on the next edge. Next_PC=PC.
- REQ: Mem_Req=1, Mem_Addr=PC.
  - With Mem_Ack: Instr<=Mem_Data, Instr_Valid<=1, Next_PC=PC+1 (8-bit wrap, 8'hFF -> 8'h00), state goes to HOLD.
  - Without Mem_Ack: Next_PC=PC and the state stays in REQ.
- HOLD: Mem_Req=0, Next_PC=PC.
  - A transfer occurs when Instr_Valid and Instr_Ready are both high. It sets Instr_Valid<=0.
  - After a transfer, the state goes to HALTED if Instr[15:12]==OPC_HALT (4'hF). Otherwise it goes to REQ.
- HALTED: Mem_Req=0, Instr_Valid=0, Halted=1, Next_PC=PC. The only exit is reset.
- Branch_Taken in IDLE, REQ or HOLD:
  - Next_PC=Branch_Target, Instr_Valid<=0, state goes to REQ.
  - Has priority over every other event in the same cycle.
  - A Mem_Ack in the same cycle is discarded: Instr is not updated and PC is not incremented.
  - Instr_Ready in the same cycle in HOLD: the handshake still counts as a transfer. The instruction is consumed and the redirect still applies. A HALT consumed this way does not enter HALTED.
- Branch_Taken in HALTED is ignored.
- Mem_Ack while Mem_Req=0 is ignored.
- Mem_Req may drop before acknowledge only on a branch redirect. Memory tolerates this withdrawal.

## Timing
- Mem_Req, Mem_Addr and Next_PC are combinational from state, PC, Mem_Ack and Branch_Taken. All other outputs are registered.
- Fetch latency: Mem_Ack in cycle N gives Instr_Valid=1 in cycle N+1, and PC=old PC+1 in cycle N+1.
- Minimum period per instruction: 2 cycles (REQ with immediate ack, then HOLD with Instr_Ready=1).
- First Mem_Req: the second rising edge after Clear_n deasserts, because IDLE takes one cycle.
- Branch_Taken in cycle N: PC=Branch_Target and state=REQ in cycle N+1, with Mem_Addr=Branch_Target.
- Asynchronous Clear_n mid-fetch forces IDLE immediately and drops Mem_Req in the same cycle. The PC register is reset separately.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, REQ, HOLD, HALTED)
  - OPC_HALT=4'hF
  - the ADDR_W and INSTR_W defaults.
- No sub-module. It is a single FSM plus the Instr register. The PC register remains a separate block in the top level.

## Test plan
- Reset then ack every request, Mem_Data=16'h1000+addr, Instr_Ready=1, PC starts at 00 -> Instr 1000, 1001, 1002 delivered on alternate cycles; PC increments 00->01->02.
- PC=8'hFF, ack with 16'h2ABC -> Instr=2ABC, Next_PC=8'h00.
- Mem_Ack held low 5 cycles at PC=10 -> Mem_Req stays 1, PC stays 10, Instr_Valid stays 0; an ack on cycle 6 delivers the instruction.
- Branch_Taken with Branch_Target=8'h40 in the same cycle as Mem_Ack at PC=05 -> ack discarded, PC=40, next Mem_Addr=40, Instr_Valid=0.
- Fetch 16'hF000 at PC=07, Instr_Ready=1 -> transfer, Halted=1, Mem_Req=0 forever, PC stays 08; Branch_Taken ignored.
- Clear_n asserted low while in REQ -> Mem_Req drops the same cycle, Instr_Valid=0, Instr=0000; the first request after release occurs at the second edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the HALT opcode and the fetch FSM state encoding.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input logic [3:0] opcode);
        return opcode == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests the word at PC, holds it for decode
// behind a valid/ready handshake and steers the PC register via Next_PC.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               Clk,
    input  logic               Clear_n,
    input  logic [ADDR_W-1:0]  PC,
    output logic [ADDR_W-1:0]  Next_PC,
    output logic               Mem_Req,
    output logic [ADDR_W-1:0]  Mem_Addr,
    input  logic               Mem_Ack,
    input  logic [INSTR_W-1:0] Mem_Data,
    output logic [INSTR_W-1:0] Instr,
    output logic               Instr_Valid,
    input  logic               Instr_Ready,
    input  logic               Branch_Taken,
    input  logic [ADDR_W-1:0]  Branch_Target,
    output logic               Halted
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic               instr_valid_q, instr_valid_d;
    logic               halted_q;
    logic               load_instr;
    logic               mem_req_c;
    logic [ADDR_W-1:0]  next_pc_c;
    logic               redirect;

    // A branch redirects from any live state; once halted only reset exits.
    assign redirect = Branch_Taken && (state_q != HALTED);

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q;
        load_instr    = 1'b0;
        mem_req_c     = 1'b0;
        next_pc_c     = PC;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                mem_req_c = 1'b1;
                if (Mem_Ack) begin
                    load_instr    = 1'b1;
                    instr_valid_d = 1'b1;
                    next_pc_c     = PC + ADDR_W'(1);
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (instr_valid_q && Instr_Ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = is_halt(instr_q[INSTR_W-1 -: 4]) ? HALTED : REQ;
                end
            end
            HALTED: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d       = IDLE;
                instr_valid_d = 1'b0;
            end
        endcase

        // The redirect withdraws any outstanding request and discards a
        // same-cycle ack; a same-cycle transfer is consumed but cannot halt.
        if (redirect) begin
            state_d       = REQ;
            next_pc_c     = Branch_Target;
            instr_valid_d = 1'b0;
            load_instr    = 1'b0;
            mem_req_c     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= (state_d == HALTED);
            if (load_instr) begin
                instr_q <= Mem_Data;
            end
        end
    end

    assign Mem_Req     = mem_req_c;
    assign Mem_Addr    = PC;
    assign Next_PC     = next_pc_c;
    assign Instr       = instr_q;
    assign Instr_Valid = instr_valid_q;
    assign Halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// each cycle compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Clear_n = 1'b0;
    logic [7:0]  PC = 8'h00;
    logic [7:0]  Next_PC;
    logic        Mem_Req;
    logic [7:0]  Mem_Addr;
    logic        Mem_Ack = 1'b0;
    logic [15:0] Mem_Data = 16'h0000;
    logic [15:0] Instr;
    logic        Instr_Valid;
    logic        Instr_Ready = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [7:0]  Branch_Target = 8'h00;
    logic        Halted;

    fetch_unit dut (
        .Clk           (Clk),
        .Clear_n       (Clear_n),
        .PC            (PC),
        .Next_PC       (Next_PC),
        .Mem_Req       (Mem_Req),
        .Mem_Addr      (Mem_Addr),
        .Mem_Ack       (Mem_Ack),
        .Mem_Data      (Mem_Data),
        .Instr         (Instr),
        .Instr_Valid   (Instr_Valid),
        .Instr_Ready   (Instr_Ready),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Halted        (Halted)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: "started" (one cycle past reset), a buffered instruction
    // awaiting decode, and a sticky halt flag.
    bit          m_idle   = 1'b1;
    bit          m_valid  = 1'b0;
    bit          m_halted = 1'b0;
    logic [15:0] m_instr  = 16'h0000;
    logic [15:0] delivered[$];

    logic        s_req;
    logic [7:0]  s_next;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle   = 1'b1;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_instr  = 16'h0000;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs,
    // then advance the model and the PC register across the rising edge.
    task automatic step(input bit ack, input bit rdy, input bit br,
                        input logic [7:0] tgt, input logic [15:0] data);
        logic       exp_req;
        logic [7:0] exp_next;
        @(negedge Clk);
        Mem_Ack       = ack;
        Instr_Ready   = rdy;
        Branch_Taken  = br;
        Branch_Target = tgt;
        Mem_Data      = data;
        #1;
        exp_req = !m_idle && !m_halted && !m_valid && !br;
        if (m_halted)           exp_next = PC;
        else if (br)            exp_next = tgt;
        else if (exp_req && ack) exp_next = PC + 8'd1;
        else                    exp_next = PC;
        check("mem_req",     Mem_Req,     exp_req);
        check("mem_addr",    Mem_Addr,    PC);
        check("next_pc",     Next_PC,     exp_next);
        check("instr_valid", Instr_Valid, m_valid);
        check("instr",       Instr,       m_instr);
        check("halted",      Halted,      m_halted);
        s_req  = Mem_Req;
        s_next = Next_PC;
        if (!m_halted && m_valid && rdy) delivered.push_back(m_instr);
        @(posedge Clk);
        #1;
        if (m_halted) begin
        end else if (br) begin
            m_idle  = 1'b0;
            m_valid = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 1'b0;
                if (m_instr[15:12] == 4'hF) m_halted = 1'b1;
            end
        end else if (ack) begin
            m_instr = data;
            m_valid = 1'b1;
        end
        PC = exp_next;
    endtask

    // Clear_n falls mid-cycle and releases just after a rising edge, so the
    // next step sees exactly one IDLE cycle.
    task automatic apply_reset();
        @(negedge Clk);
        #2;
        Clear_n = 1'b0;
        model_reset();
        #1;
        check("rst_mem_req",     Mem_Req,     1'b0);
        check("rst_instr_valid", Instr_Valid, 1'b0);
        check("rst_instr",       Instr,       16'h0000);
        check("rst_halted",      Halted,      1'b0);
        Mem_Ack      = 1'b0;
        Branch_Taken = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        Clear_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int halt_cycles;
        logic [15:0] rdata;

        // Back-to-back fetches from PC=00.
        PC = 8'h00;
        apply_reset();
        step(1, 1, 0, 8'h00, 16'h1000 + PC);
        check("first_cycle_idle_req", s_req, 1'b0);
        repeat (6) step(1, 1, 0, 8'h00, 16'h1000 + PC);
        check("n_delivered", delivered.size(), 3);
        if (delivered.size() >= 3) begin
            check("deliver0", delivered[0], 16'h1000);
            check("deliver1", delivered[1], 16'h1001);
            check("deliver2", delivered[2], 16'h1002);
        end
        check("pc_after_three", PC, 8'h03);

        // PC wrap.
        PC = 8'hFF;
        step(1, 0, 0, 8'h00, 16'h2ABC);
        check("wrap_next_pc", s_next, 8'h00);
        check("wrap_instr", Instr, 16'h2ABC);
        check("wrap_valid", Instr_Valid, 1'b1);
        step(0, 1, 0, 8'h00, 16'h0000);

        // Memory stall.
        PC = 8'h10;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'h00, 16'h0000);
            check("stall_req", s_req, 1'b1);
            check("stall_pc", PC, 8'h10);
            check("stall_valid", Instr_Valid, 1'b0);
        end
        step(1, 0, 0, 8'h00, 16'h1010);
        check("stall_instr", Instr, 16'h1010);
        check("stall_pc_inc", PC, 8'h11);
        step(0, 1, 0, 8'h00, 16'h0000);

        // Branch with a same-cycle ack.
        PC = 8'h05;
        step(1, 0, 1, 8'h40, 16'h5555);
        check("br_next_pc", s_next, 8'h40);
        check("br_mem_addr", Mem_Addr, 8'h40);
        check("br_valid", Instr_Valid, 1'b0);
        check("br_instr_kept", Instr, 16'h1010);

        // HALT, then everything ignored.
        PC = 8'h07;
        step(1, 0, 0, 8'h00, 16'hF000);
        step(0, 1, 0, 8'h00, 16'h0000);
        check("halt_flag", Halted, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom), 1'($urandom), 1'b1, 8'($urandom), 16'($urandom));
            check("halt_no_req", s_req, 1'b0);
        end
        check("halt_pc", PC, 8'h08);

        // Reset while a request is outstanding.
        apply_reset();
        step(0, 0, 0, 8'h00, 16'h0000);
        step(0, 0, 0, 8'h00, 16'h0000);
        check("req_before_clear", Mem_Req, 1'b1);
        apply_reset();
        step(0, 0, 0, 8'h00, 16'h0000);
        check("post_clear_idle", s_req, 1'b0);
        step(0, 0, 0, 8'h00, 16'h0000);
        check("post_clear_req", s_req, 1'b1);

        // Random traffic, restarting whenever the stage halts.
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            rdata = 16'($urandom);
            if ($urandom_range(0, 7) != 0) rdata[15:12] = 4'($urandom_range(0, 14));
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                 8'($urandom), rdata);
            if (m_halted) halt_cycles++;
            if (halt_cycles > 4) begin
                halt_cycles = 0;
                PC = 8'($urandom);
                apply_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
